// File: rtl/synthesizer_channel_mixer.sv
// synthesizer_channel_mixer
// Per-channel enable/gain stage between the channelizer and the synthesizer.
// Each accepted I/Q sample is scaled by its channel's unsigned gain (GAIN_FRAC
// fractional bits), rounded half-up, and saturated to DATA_WIDTH. Disabled or
// out-of-range channels produce zero data. The gain table is double-buffered:
// config writes land in a shadow table, and a commit arms a shadow->active
// swap that happens only when the last sample of a frame is accepted.
// Fixed 3-cycle latency (lookup, multiply, round/saturate) and no backpressure.
//
// Ports
//   Clk, Rst              clock, async active-high reset
//   Input_*               sample stream in: valid, index, last, data[0]=I, data[1]=Q
//   Config_*              shadow-table write (valid/index/enable/gain) and commit
//   Output_*              sample stream out; sidebands hold between samples, data is 0
//   Status_swap_pending   commit armed, swap not yet performed
//   Error_saturation      pulse with the output sample whose I or Q clipped
//   Error_index_sequence  pulse with the output sample whose index was unexpected
module synthesizer_channel_mixer #(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 24,
    parameter int GAIN_WIDTH          = 16,
    parameter int GAIN_FRAC           = 14
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic                                 Input_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0]       Input_index,
    input  logic                                 Input_last,
    input  logic [1:0][DATA_WIDTH-1:0]           Input_data,
    input  logic                                 Config_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0]       Config_index,
    input  logic                                 Config_enable,
    input  logic [GAIN_WIDTH-1:0]                Config_gain,
    input  logic                                 Config_commit,
    output logic                                 Output_valid,
    output logic [CHANNEL_INDEX_WIDTH-1:0]       Output_index,
    output logic                                 Output_last,
    output logic [1:0][DATA_WIDTH-1:0]           Output_data,
    output logic                                 Status_swap_pending,
    output logic                                 Error_saturation,
    output logic                                 Error_index_sequence
);
    localparam int CIW = CHANNEL_INDEX_WIDTH;
    localparam int PW  = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH-1:0] UNITY     = GAIN_WIDTH'(2**GAIN_FRAC);
    localparam logic signed [PW-1:0]  ROUND_ADD = PW'(2**(GAIN_FRAC-1));
    localparam logic signed [PW-1:0]  SAT_MAX   = PW'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [PW-1:0]  SAT_MIN   = -PW'(2**(DATA_WIDTH-1));

    logic                  r_act_en   [NUM_CHANNELS];
    logic [GAIN_WIDTH-1:0] r_act_gain [NUM_CHANNELS];
    logic                  r_sh_en    [NUM_CHANNELS];
    logic [GAIN_WIDTH-1:0] r_sh_gain  [NUM_CHANNELS];
    logic                  w_sh_en_nxt   [NUM_CHANNELS];
    logic [GAIN_WIDTH-1:0] w_sh_gain_nxt [NUM_CHANNELS];
    logic                  r_pending;
    logic [CIW-1:0]        r_exp_idx;

    logic w_cfg_in_range, w_in_range, w_idx_err, w_swap;

    // Stage registers
    logic                   r1_valid, r1_last, r1_err;
    logic [CIW-1:0]         r1_index;
    logic [1:0][DATA_WIDTH-1:0] r1_data;
    logic [GAIN_WIDTH-1:0]  r1_gain;
    logic                   r2_valid, r2_last, r2_err;
    logic [CIW-1:0]         r2_index;
    logic signed [PW-1:0]   r2_prod [2];

    logic signed [PW-1:0]       w_round [2];
    logic [1:0][DATA_WIDTH-1:0] w_res;
    logic                       w_clip;

    assign w_cfg_in_range = {1'b0, Config_index} < (CIW+1)'(NUM_CHANNELS);
    assign w_in_range     = {1'b0, Input_index}  < (CIW+1)'(NUM_CHANNELS);
    assign w_idx_err      = Input_valid && (!w_in_range || (Input_index != r_exp_idx));
    assign w_swap         = Input_valid && Input_last && r_pending;
    assign Status_swap_pending = r_pending;

    // Shadow contents after this cycle's write; the swap copies this so a
    // write landing on the frame's last sample is still part of the swap.
    always_comb begin
        w_sh_en_nxt   = r_sh_en;
        w_sh_gain_nxt = r_sh_gain;
        if (Config_valid && w_cfg_in_range) begin
            w_sh_en_nxt[Config_index]   = Config_enable;
            w_sh_gain_nxt[Config_index] = Config_gain;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_act_en   <= '{default: 1'b1};
            r_act_gain <= '{default: UNITY};
            r_sh_en    <= '{default: 1'b1};
            r_sh_gain  <= '{default: UNITY};
            r_pending  <= 1'b0;
            r_exp_idx  <= '0;
        end else begin
            r_sh_en   <= w_sh_en_nxt;
            r_sh_gain <= w_sh_gain_nxt;
            if (w_swap) begin
                r_act_en   <= w_sh_en_nxt;
                r_act_gain <= w_sh_gain_nxt;
                r_pending  <= Config_commit;
            end else if (Config_commit) begin
                r_pending <= 1'b1;
            end
            if (Input_valid) begin
                // Resync to the received index so one glitch flags only once.
                r_exp_idx <= Input_last ? '0 : Input_index + CIW'(1);
            end
        end
    end

    // S1: lookup. A disabled or out-of-range channel gets gain 0, which
    // rounds to exactly 0 and can never clip.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r1_valid <= 1'b0;
            r1_last  <= 1'b0;
            r1_err   <= 1'b0;
            r1_index <= '0;
            r1_data  <= '0;
            r1_gain  <= '0;
        end else begin
            r1_valid <= Input_valid;
            r1_err   <= w_idx_err;
            r1_data  <= Input_data;
            r1_gain  <= (w_in_range && r_act_en[Input_index]) ? r_act_gain[Input_index] : '0;
            if (Input_valid) begin
                r1_index <= Input_index;
                r1_last  <= Input_last;
            end
        end
    end

    // S2: signed data times zero-extended gain.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r2_valid   <= 1'b0;
            r2_last    <= 1'b0;
            r2_err     <= 1'b0;
            r2_index   <= '0;
            r2_prod[0] <= '0;
            r2_prod[1] <= '0;
        end else begin
            r2_valid   <= r1_valid;
            r2_last    <= r1_last;
            r2_err     <= r1_err;
            r2_index   <= r1_index;
            r2_prod[0] <= PW'($signed(r1_data[0])) * PW'($signed({1'b0, r1_gain}));
            r2_prod[1] <= PW'($signed(r1_data[1])) * PW'($signed({1'b0, r1_gain}));
        end
    end

    // S3: round half up, then clip to the signed output range.
    always_comb begin
        w_clip = 1'b0;
        w_res  = '0;
        for (int k = 0; k < 2; k++) begin
            w_round[k] = (r2_prod[k] + ROUND_ADD) >>> GAIN_FRAC;
            if (w_round[k] > SAT_MAX) begin
                w_res[k] = SAT_MAX[DATA_WIDTH-1:0];
                w_clip   = 1'b1;
            end else if (w_round[k] < SAT_MIN) begin
                w_res[k] = SAT_MIN[DATA_WIDTH-1:0];
                w_clip   = 1'b1;
            end else begin
                w_res[k] = w_round[k][DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Output_valid         <= 1'b0;
            Output_index         <= '0;
            Output_last          <= 1'b0;
            Output_data          <= '0;
            Error_saturation     <= 1'b0;
            Error_index_sequence <= 1'b0;
        end else begin
            Output_valid         <= r2_valid;
            Output_data          <= r2_valid ? w_res : '0;
            Error_saturation     <= r2_valid && w_clip;
            Error_index_sequence <= r2_valid && r2_err;
            if (r2_valid) begin
                Output_index <= r2_index;
                Output_last  <= r2_last;
            end
        end
    end
endmodule

// File: tb/tb_synthesizer_channel_mixer.sv
module tb_synthesizer_channel_mixer;
    localparam int CIW = 4;
    localparam int DW  = 24;
    localparam int GW  = 16;

    logic Clk = 1'b0;
    logic Rst;
    logic Input_valid, Input_last, Config_valid, Config_enable, Config_commit;
    logic [CIW-1:0] Input_index, Config_index;
    logic [1:0][DW-1:0] Input_data;
    logic [GW-1:0] Config_gain;
    logic Output_valid, Output_last, Status_swap_pending, Error_saturation, Error_index_sequence;
    logic [CIW-1:0] Output_index;
    logic [1:0][DW-1:0] Output_data;

    always #5 Clk = ~Clk;

    synthesizer_channel_mixer dut (
        .Clk(Clk), .Rst(Rst),
        .Input_valid(Input_valid), .Input_index(Input_index), .Input_last(Input_last),
        .Input_data(Input_data),
        .Config_valid(Config_valid), .Config_index(Config_index), .Config_enable(Config_enable),
        .Config_gain(Config_gain), .Config_commit(Config_commit),
        .Output_valid(Output_valid), .Output_index(Output_index), .Output_last(Output_last),
        .Output_data(Output_data), .Status_swap_pending(Status_swap_pending),
        .Error_saturation(Error_saturation), .Error_index_sequence(Error_index_sequence)
    );

    typedef struct {
        int idx; bit last; int di; int dq; int ei; int eq; bit esat; bit eerr;
    } vec_t;
    typedef struct {
        int idx; bit last; int ei; int eq; bit esat; bit eerr; int due;
    } exp_t;

    vec_t vt[$];
    exp_t expq[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int p = 0;

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic void add(int idx, bit last, int di, int dq, int ei, int eq, bit esat, bit eerr);
        vec_t v;
        v.idx = idx; v.last = last; v.di = di; v.dq = dq;
        v.ei = ei; v.eq = eq; v.esat = esat; v.eerr = eerr;
        vt.push_back(v);
    endfunction

    // Output monitor: samples half a cycle after the active edge.
    always @(negedge Clk) begin : mon
        exp_t e;
        int oi, oq;
        cyc++;
        if (Output_valid) begin
            if (expq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e  = expq.pop_front();
                oi = $signed(Output_data[0]);
                oq = $signed(Output_data[1]);
                chk("latency_cycle", cyc, e.due);
                chk("out_index", longint'(Output_index), e.idx);
                chk("out_last", longint'(Output_last), longint'(e.last));
                chk("out_i", oi, e.ei);
                chk("out_q", oq, e.eq);
                chk("err_saturation", longint'(Error_saturation), longint'(e.esat));
                chk("err_index_seq", longint'(Error_index_sequence), longint'(e.eerr));
            end
        end else begin
            chk("idle_data_zero", longint'(Output_data), 0);
            chk("idle_no_pulses", longint'({Error_saturation, Error_index_sequence}), 0);
            if (expq.size() > 0 && expq[0].due <= cyc) begin
                chk("missing_valid", 0, 1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic play(int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk); #1;
            Input_valid   = 1'b1;
            Input_index   = CIW'(vt[p].idx);
            Input_last    = vt[p].last;
            Input_data[0] = DW'(vt[p].di);
            Input_data[1] = DW'(vt[p].dq);
            e.idx = vt[p].idx; e.last = vt[p].last; e.ei = vt[p].ei; e.eq = vt[p].eq;
            e.esat = vt[p].esat; e.eerr = vt[p].eerr; e.due = cyc + 3;
            expq.push_back(e);
            p++;
        end
        @(negedge Clk); #1;
        Input_valid = 1'b0;
        Input_last  = 1'b0;
        Input_data  = '0;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && expq.size() > 0; k++) @(negedge Clk);
        if (expq.size() > 0) begin
            chk("drain_timeout", expq.size(), 0);
            expq.delete();
        end
        @(negedge Clk); #1;
    endtask

    task automatic cfg(int idx, bit en, int gain, bit commit);
        @(negedge Clk); #1;
        Config_valid  = 1'b1;
        Config_index  = CIW'(idx);
        Config_enable = en;
        Config_gain   = GW'(gain);
        Config_commit = commit;
        @(negedge Clk); #1;
        Config_valid  = 1'b0;
        Config_commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // F0: reset table is pass-through
        for (int k = 0; k < 16; k++) add(k, k == 15, 1000, -1000, 1000, -1000, 0, 0);
        // F1: ch3 at 0.5 committed but not yet active
        for (int k = 0; k < 16; k++) add(k, k == 15, 3, -3, 3, -3, 0, 0);
        // F2 and F3: ch3 active at 0.5 -> 1.5 rounds to 2, -1.5 rounds to -1
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 16; k++)
                if (k == 3) add(k, k == 15, 3, -3, 2, -1, 0, 0);
                else        add(k, k == 15, 3, -3, 3, -3, 0, 0);
        // F4: ch5 x2 clips, ch7 disabled gives zero without clipping
        for (int k = 0; k < 16; k++)
            if (k == 3)      add(k, k == 15, 3, -3, 2, -1, 0, 0);
            else if (k == 5) add(k, k == 15, 32'h7FFFFF, -32'h800000, 32'h7FFFFF, -32'h800000, 1, 0);
            else if (k == 7) add(k, k == 15, 32'h7FFFFF, -32'h800000, 0, 0, 0, 0);
            else             add(k, k == 15, 500, -500, 500, -500, 0, 0);
        // F5: index 3 skipped; error only on index 4
        for (int k = 0; k < 16; k++)
            if (k == 3)      ;
            else if (k == 4) add(k, 0, 100, -100, 100, -100, 0, 1);
            else if (k == 5) add(k, 0, 100, -100, 200, -200, 0, 0);
            else if (k == 7) add(k, 0, 100, -100, 0, 0, 0, 0);
            else             add(k, k == 15, 100, -100, 100, -100, 0, 0);
        // F6: after mid-frame reset, pass-through again
        for (int k = 0; k < 16; k++) add(k, k == 15, 1000, -1000, 1000, -1000, 0, 0);

        Rst = 1'b1;
        Input_valid = 1'b0; Input_index = '0; Input_last = 1'b0; Input_data = '0;
        Config_valid = 1'b0; Config_index = '0; Config_enable = 1'b0; Config_gain = '0;
        Config_commit = 1'b0;
        repeat (3) @(negedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk); #1;
        chk("reset_valid", longint'(Output_valid), 0);
        chk("reset_data", longint'(Output_data), 0);
        chk("reset_index", longint'(Output_index), 0);
        chk("reset_last", longint'(Output_last), 0);
        chk("reset_pending", longint'(Status_swap_pending), 0);

        play(16); drain();
        chk("hold_index_after_frame", longint'(Output_index), 15);
        chk("hold_last_after_frame", longint'(Output_last), 1);

        cfg(3, 1, 16'h2000, 1);
        chk("pending_after_commit", longint'(Status_swap_pending), 1);
        play(16); drain();
        chk("pending_after_swap", longint'(Status_swap_pending), 0);
        play(16); drain();

        cfg(5, 1, 16'h8000, 1);
        chk("pending_ch5_commit", longint'(Status_swap_pending), 1);
        cfg(7, 0, 16'h4000, 1);
        chk("pending_commit_while_pending", longint'(Status_swap_pending), 1);
        play(16); drain();
        chk("pending_after_swap2", longint'(Status_swap_pending), 0);
        play(16); drain();
        play(15); drain();

        // Mid-frame reset: two samples in flight must never appear.
        cfg(0, 1, 16'h1000, 1);
        chk("pending_before_reset", longint'(Status_swap_pending), 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk); #1;
            Input_valid = 1'b1; Input_index = CIW'(k); Input_last = 1'b0;
            Input_data[0] = DW'(1234); Input_data[1] = DW'(-1234);
        end
        @(negedge Clk); #1;
        Input_valid = 1'b0; Input_data = '0;
        Rst = 1'b1;
        @(negedge Clk); #1;
        Rst = 1'b0;
        repeat (6) @(negedge Clk);
        #1;
        chk("pending_after_reset", longint'(Status_swap_pending), 0);
        play(16); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
